// File: rtl/seq_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module   : seq_prio_enc
//  Purpose  : Sequential priority encoder. Requests on y_in are captured into
//             a pending register; the highest-index pending bit is presented
//             as an encoded index with a valid/ready handshake. Accepted bits
//             are cleared, accepts are counted, and a sticky flag records any
//             request that lands on a bit which is already pending.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk      in   1   rising-edge clock
//    rst_n    in   1   asynchronous active-low reset
//    y_in     in   N   request lines (multi-hot allowed), sampled every edge
//    rdy      in   1   consumer ready; accept = v & rdy
//    ovf_clr  in   1   synchronous clear of ovf (a new overflow wins)
//    I        out  W   encoded index of the presented request
//    v        out  1   I is valid
//    pend     out  N   pending-request register
//    ovf      out  1   sticky overflow flag
//    cnt      out  8   accepted-code counter, wraps 255 -> 0
// ============================================================================
module seq_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] y_in,
  input  logic         rdy,
  input  logic         ovf_clr,
  output logic [W-1:0] I,
  output logic         v,
  output logic [N-1:0] pend,
  output logic         ovf,
  output logic [7:0]   cnt
);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_PRESENT = 1'b1;

  logic [0:0]   r_state;
  logic [0:0]   w_state_nxt;
  logic [W-1:0] r_idx;
  logic [N-1:0] r_pend;
  logic         r_ovf;
  logic [7:0]   r_cnt;

  logic         w_v;
  logic         w_accept;
  logic [N-1:0] w_clr_mask;
  logic [N-1:0] w_pend_nxt;
  logic [N-1:0] w_src;
  logic         w_load;
  logic         w_ovf_set;

  // Highest-index set bit wins; an all-zero vector encodes to 0.
  function automatic logic [W-1:0] f_prio(input logic [N-1:0] vec);
    logic [W-1:0] res;
    res = '0;
    for (int k = 0; k < N; k++) begin
      if (vec[k]) res = W'(k);
    end
    return res;
  endfunction

  assign w_accept   = w_v & rdy;
  assign w_clr_mask = w_accept ? ({{(N-1){1'b0}}, 1'b1} << r_idx) : '0;
  // A fresh request on the bit being cleared survives (set beats clear).
  assign w_pend_nxt = (r_pend & ~w_clr_mask) | y_in;
  assign w_ovf_set  = |(y_in & r_pend & ~w_clr_mask);

  // From IDLE the code comes from the registered pend (one cycle after it
  // becomes nonzero); on an accept it comes from the post-clear vector so
  // the next code follows on the very next cycle without a bubble.
  assign w_src  = (r_state == S_IDLE) ? r_pend : w_pend_nxt;
  assign w_load = (r_state == S_IDLE) ? (|r_pend) : (w_accept & (|w_pend_nxt));

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (|r_pend) w_state_nxt = S_PRESENT;
      end
      S_PRESENT: begin
        // The presented code is held until accepted; no preemption.
        if (w_accept && !(|w_pend_nxt)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_v = 1'b0;
    case (r_state)
      S_PRESENT: w_v = 1'b1;
      default:   w_v = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (w_load) begin
      r_idx <= f_prio(w_src);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign I    = r_idx;
  assign v    = w_v;
  assign pend = r_pend;
  assign ovf  = r_ovf;
  assign cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seq_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_prio_enc
//  Purpose  : Self-checking bench for seq_prio_enc. A driver issues stimulus
//             and steps a behavioural reference model, pushing the expected
//             per-cycle status and the expected accepted codes into queues;
//             an independent monitor pops and compares them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_prio_enc;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] y_in;
  logic         rdy;
  logic         ovf_clr;
  logic [W-1:0] I;
  logic         v;
  logic [N-1:0] pend;
  logic         ovf;
  logic [7:0]   cnt;

  seq_prio_enc #(.N(N), .W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .y_in    (y_in),
    .rdy     (rdy),
    .ovf_clr (ovf_clr),
    .I       (I),
    .v       (v),
    .pend    (pend),
    .ovf     (ovf),
    .cnt     (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [W-1:0] i;
    logic [N-1:0] pend;
    logic         ovf;
    logic [7:0]   cnt;
  } stat_t;

  stat_t sq[$];   // expected status after each driven edge
  int    cq[$];   // expected accepted codes, in order

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: set of pending requests, the code currently offered
  // (-1 when nothing is offered), the sticky flag and the accept count.
  logic [N-1:0] m_pend;
  int           m_cur;
  int           m_cnt;
  bit           m_ovf;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int highest(input logic [N-1:0] vec);
    int h = -1;
    for (int k = 0; k < N; k++) if (vec[k]) h = k;
    return h;
  endfunction

  task automatic model_reset();
    m_pend = '0;
    m_cur  = -1;
    m_cnt  = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] y, input logic r, input logic c);
    bit           acc;
    logic [N-1:0] mask;
    logic [N-1:0] newp;
    stat_t        s;
    acc  = (m_cur >= 0) && r;
    mask = '0;
    if (acc) mask[m_cur] = 1'b1;
    newp = (m_pend & ~mask) | y;
    if ((y & m_pend & ~mask) != '0) m_ovf = 1'b1;
    else if (c)                     m_ovf = 1'b0;
    if (acc) begin
      cq.push_back(m_cur);
      m_cnt = (m_cnt + 1) % 256;
    end
    if (m_cur < 0)  m_cur = highest(m_pend);
    else if (acc)   m_cur = highest(newp);
    m_pend = newp;
    s.v    = (m_cur >= 0);
    s.i    = (m_cur >= 0) ? W'(m_cur) : '0;
    s.pend = m_pend;
    s.ovf  = m_ovf;
    s.cnt  = 8'(m_cnt);
    sq.push_back(s);
  endtask

  task automatic drive(input logic [N-1:0] y, input logic r, input logic c);
    @(negedge clk);
    #1;
    y_in    = y;
    rdy     = r;
    ovf_clr = c;
    model_step(y, r, c);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: captures the handshake just before each edge, then compares the
  // post-edge state against the scoreboard.
  task automatic monitor();
    bit           hs;
    logic [W-1:0] cap_i;
    stat_t        s;
    int           e;
    forever begin
      @(negedge clk);
      #3;
      hs    = v && rdy;
      cap_i = I;
      @(posedge clk);
      #1;
      if (hs) begin
        if (cq.size() > 0) begin
          e = cq.pop_front();
          check("accept_code", int'(cap_i), e);
        end else begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_accept: got code %0d expected no accept at %0t", cap_i, $time);
        end
      end
      if (sq.size() > 0) begin
        s = sq.pop_front();
        check("v", int'(v), int'(s.v));
        if (s.v) check("I", int'(I), int'(s.i));
        check("pend", int'(pend), int'(s.pend));
        check("ovf", int'(ovf), int'(s.ovf));
        check("cnt", int'(cnt), int'(s.cnt));
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    y_in    = '0;
    rdy     = 1'b0;
    ovf_clr = 1'b0;
    model_reset();

    #1;
    check("rst_v", int'(v), 0);
    check("rst_I", int'(I), 0);
    check("rst_pend", int'(pend), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_cnt", int'(cnt), 0);

    @(negedge clk);
    #2;
    rst_n = 1'b1;

    fork
      monitor();
    join_none

    // Single request, consumer always ready.
    drive(4'b0100, 1'b1, 1'b0);
    drive(4'b0000, 1'b1, 1'b0);
    settle();
    check("single_v", int'(v), 1);
    check("single_I", int'(I), 2);
    drive(4'b0000, 1'b1, 1'b0);
    settle();
    check("single_done_v", int'(v), 0);
    check("single_done_pend", int'(pend), 0);
    check("single_done_cnt", int'(cnt), 1);

    // Multi-hot with back-pressure.
    drive(4'b1011, 1'b0, 1'b0);
    repeat (3) drive(4'b0000, 1'b0, 1'b0);
    settle();
    check("bp_hold_I", int'(I), 3);
    drive(4'b0000, 1'b1, 1'b0);
    settle();
    check("bp_next_I1", int'(I), 1);
    drive(4'b0000, 1'b1, 1'b0);
    settle();
    check("bp_next_I0", int'(I), 0);
    drive(4'b0000, 1'b1, 1'b0);
    settle();
    check("bp_done_v", int'(v), 0);
    check("bp_done_cnt", int'(cnt), 4);  // three accepts plus the one above

    // Overflow set, clear, and re-request on the bit being accepted.
    drive(4'b0010, 1'b0, 1'b0);
    drive(4'b0010, 1'b0, 1'b0);
    settle();
    check("ovf_set", int'(ovf), 1);
    drive(4'b0000, 1'b0, 1'b1);
    settle();
    check("ovf_clr", int'(ovf), 0);
    drive(4'b0010, 1'b1, 1'b0);
    settle();
    check("ovf_rereq_ovf", int'(ovf), 0);
    check("ovf_rereq_pend1", int'(pend[1]), 1);
    repeat (3) drive(4'b0000, 1'b1, 1'b0);

    // Asynchronous reset while presenting code 3.
    drive(4'b1000, 1'b0, 1'b0);
    for (int k = 0; k < 4 && m_cur != 3; k++) drive(4'b0000, 1'b0, 1'b0);
    drive(4'b0000, 1'b0, 1'b0);
    settle();
    check("pre_rst_v", int'(v), 1);
    check("pre_rst_I", int'(I), 3);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_v", int'(v), 0);
    check("async_rst_I", int'(I), 0);
    check("async_rst_pend", int'(pend), 0);
    check("async_rst_cnt", int'(cnt), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // Counter wrap: continuous back-to-back accepts.
    repeat (300) drive(4'b0001, 1'b1, 1'b0);
    repeat (3) drive(4'b0000, 1'b1, 1'b0);

    // Randomised traffic.
    repeat (2000) begin
      drive(4'($urandom_range(0, 15) & $urandom_range(0, 15)),
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 7) == 0));
    end

    repeat (8) drive(4'b0000, 1'b1, 1'b0);
    settle();
    check("codes_left", cq.size(), 0);
    check("status_left", sq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
